// File: rtl/axi_inflight_limiter.sv
// rtl/axi_inflight_limiter.sv - AXI outstanding-transaction limiter with AR/AW gating
//
// Purpose:
//   Counts outstanding reads (AR accepted, R-last not yet seen) and writes
//   (AW accepted, B not yet seen). New AR/AW requests are held off while the
//   matching count sits at its limit. All payloads pass through combinationally.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   slv_req_i          request from upstream (delay stage output)
//   slv_resp_o         response to upstream
//   mst_req_o          request to downstream slave
//   mst_resp_i         response from downstream slave
//   rd_inflight_o      current outstanding read count
//   wr_inflight_o      current outstanding write count
//   idle_o             both counts are zero
//   stats_clr_i        (AXI_INFLIGHT_LIMITER_STATS_EN) synchronous clear of stall counters
//   rd_stall_cycles_o  (AXI_INFLIGHT_LIMITER_STATS_EN) cycles an upstream AR was blocked
//   wr_stall_cycles_o  (AXI_INFLIGHT_LIMITER_STATS_EN) cycles an upstream AW was blocked
//
// Optional feature macro: AXI_INFLIGHT_LIMITER_STATS_EN

package axi_inflight_limiter_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        r_chan_t  r;
        logic     r_valid;
    } axi_resp_t;

endpackage

module axi_inflight_limiter #(
    parameter type aw_chan_t  = axi_inflight_limiter_pkg::aw_chan_t,
    parameter type w_chan_t   = axi_inflight_limiter_pkg::w_chan_t,
    parameter type b_chan_t   = axi_inflight_limiter_pkg::b_chan_t,
    parameter type ar_chan_t  = axi_inflight_limiter_pkg::ar_chan_t,
    parameter type r_chan_t   = axi_inflight_limiter_pkg::r_chan_t,
    parameter type axi_req_t  = axi_inflight_limiter_pkg::axi_req_t,
    parameter type axi_resp_t = axi_inflight_limiter_pkg::axi_resp_t,
    parameter int unsigned MaxReads  = 4,
    parameter int unsigned MaxWrites = 4,
    localparam int unsigned CntW =
        $clog2(((MaxReads > MaxWrites) ? MaxReads : MaxWrites) + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  axi_req_t        slv_req_i,
    output axi_resp_t       slv_resp_o,
    output axi_req_t        mst_req_o,
    input  axi_resp_t       mst_resp_i,
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
    input  logic            stats_clr_i,
    output logic [31:0]     rd_stall_cycles_o,
    output logic [31:0]     wr_stall_cycles_o,
`endif
    output logic [CntW-1:0] rd_inflight_o,
    output logic [CntW-1:0] wr_inflight_o,
    output logic            idle_o
);

    logic [CntW-1:0] rd_cnt_d, rd_cnt_q;
    logic [CntW-1:0] wr_cnt_d, wr_cnt_q;
    logic            rd_full, wr_full;
    logic            rd_inc, rd_dec;
    logic            wr_inc, wr_dec;

    // Typed views of the payloads that travel through untouched.
    aw_chan_t aw_chan;
    w_chan_t  w_chan;
    b_chan_t  b_chan;
    ar_chan_t ar_chan;
    r_chan_t  r_chan;

    assign aw_chan = slv_req_i.aw;
    assign w_chan  = slv_req_i.w;
    assign ar_chan = slv_req_i.ar;
    assign b_chan  = mst_resp_i.b;
    assign r_chan  = mst_resp_i.r;

    // Full flags come straight from the registered counts, so a decrement in
    // cycle N only opens the gate in cycle N+1.
    assign rd_full = (rd_cnt_q == CntW'(MaxReads));
    assign wr_full = (wr_cnt_q == CntW'(MaxWrites));

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw       = aw_chan;
        mst_req_o.w        = w_chan;
        mst_req_o.ar       = ar_chan;
        mst_req_o.aw_valid = slv_req_i.aw_valid & ~wr_full;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ~rd_full;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.b        = b_chan;
        slv_resp_o.r        = r_chan;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_full;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_full;
    end

    assign rd_inc = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign rd_dec = mst_resp_i.r_valid & slv_req_i.r_ready & r_chan.last;
    assign wr_inc = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign wr_dec = mst_resp_i.b_valid & slv_req_i.b_ready;

    // An increment can never happen while full, so the counts never exceed
    // their limits. A stray decrement at zero leaves the count at zero.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !rd_dec) begin
            rd_cnt_d = rd_cnt_q + CntW'(1);
        end else if (rd_dec && !rd_inc && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - CntW'(1);
        end

        wr_cnt_d = wr_cnt_q;
        if (wr_inc && !wr_dec) begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
        end else if (wr_dec && !wr_inc && (wr_cnt_q != '0)) begin
            wr_cnt_d = wr_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_inflight_o = rd_cnt_q;
    assign wr_inflight_o = wr_cnt_q;
    assign idle_o        = (rd_cnt_q == '0) & (wr_cnt_q == '0);

`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
    logic [31:0] rd_stall_d, rd_stall_q;
    logic [31:0] wr_stall_d, wr_stall_q;

    // A stall cycle is one where upstream offers a request that the full flag
    // is holding back; clear beats increment, counters stick at all-ones.
    always_comb begin
        rd_stall_d = rd_stall_q;
        wr_stall_d = wr_stall_q;
        if (stats_clr_i) begin
            rd_stall_d = '0;
            wr_stall_d = '0;
        end else begin
            if (slv_req_i.ar_valid && rd_full && (rd_stall_q != '1)) begin
                rd_stall_d = rd_stall_q + 32'd1;
            end
            if (slv_req_i.aw_valid && wr_full && (wr_stall_q != '1)) begin
                wr_stall_d = wr_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_stall_q <= '0;
            wr_stall_q <= '0;
        end else begin
            rd_stall_q <= rd_stall_d;
            wr_stall_q <= wr_stall_d;
        end
    end

    assign rd_stall_cycles_o = rd_stall_q;
    assign wr_stall_cycles_o = wr_stall_q;
`endif

`ifndef SYNTHESIS
    // A last-beat response or B with nothing outstanding means the slave and
    // this block disagree, typically because only one of them was reset.
    rd_dec_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_dec && (rd_cnt_q == '0)))
        else $error("axi_inflight_limiter: R-last handshake with no outstanding read");

    wr_dec_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_dec && (wr_cnt_q == '0)))
        else $error("axi_inflight_limiter: B handshake with no outstanding write");
`endif

endmodule

// File: tb/tb_axi_inflight_limiter.sv
// tb/tb_axi_inflight_limiter.sv - randomized and directed checks of axi_inflight_limiter
module tb_axi_inflight_limiter;
    import axi_inflight_limiter_pkg::*;

    localparam int MR = 2;
    localparam int MW = 2;
    localparam int CW = $clog2(((MR > MW) ? MR : MW) + 1);

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    logic [CW-1:0] rd_inflight, wr_inflight;
    logic      idle;
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
    logic        stats_clr;
    logic [31:0] rd_stall, wr_stall;
    int          rd_stall_m, wr_stall_m;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue entry per accepted-but-unfinished transaction.
    int rd_q[$];
    int wr_q[$];
    int rd_beat = 0;
    bit ar_hs_last = 0;
    bit aw_hs_last = 0;

    always #5 clk = ~clk;

    axi_inflight_limiter #(
        .MaxReads (MR),
        .MaxWrites(MW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .slv_req_i    (slv_req),
        .slv_resp_o   (slv_resp),
        .mst_req_o    (mst_req),
        .mst_resp_i   (mst_resp),
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        .stats_clr_i      (stats_clr),
        .rd_stall_cycles_o(rd_stall),
        .wr_stall_cycles_o(wr_stall),
`endif
        .rd_inflight_o(rd_inflight),
        .wr_inflight_o(wr_inflight),
        .idle_o       (idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        slv_req  = '0;
        mst_resp = '0;
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    // One clock cycle: entered at a negedge with inputs applied, returns at the next negedge.
    task automatic step();
        bit rd_ok, wr_ok, ar_hs, aw_hs, rl_hs, b_hs, r_hs;
        #1;
        rd_ok = (rd_q.size() < MR);
        wr_ok = (wr_q.size() < MW);
        check("mst_ar_valid", mst_req.ar_valid, slv_req.ar_valid && rd_ok);
        check("slv_ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && rd_ok);
        check("mst_aw_valid", mst_req.aw_valid, slv_req.aw_valid && wr_ok);
        check("slv_aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && wr_ok);
        check("ar_payload", mst_req.ar, slv_req.ar);
        check("aw_payload", mst_req.aw, slv_req.aw);
        check("w_pass", {mst_req.w, mst_req.w_valid}, {slv_req.w, slv_req.w_valid});
        check("w_ready", slv_resp.w_ready, mst_resp.w_ready);
        check("r_pass", {slv_resp.r, slv_resp.r_valid}, {mst_resp.r, mst_resp.r_valid});
        check("b_pass", {slv_resp.b, slv_resp.b_valid}, {mst_resp.b, mst_resp.b_valid});
        check("rb_ready", {mst_req.r_ready, mst_req.b_ready}, {slv_req.r_ready, slv_req.b_ready});
        ar_hs = slv_req.ar_valid && mst_resp.ar_ready && rd_ok;
        aw_hs = slv_req.aw_valid && mst_resp.aw_ready && wr_ok;
        r_hs  = mst_resp.r_valid && slv_req.r_ready;
        rl_hs = r_hs && mst_resp.r.last;
        b_hs  = mst_resp.b_valid && slv_req.b_ready;
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        if (stats_clr) begin
            rd_stall_m = 0;
            wr_stall_m = 0;
        end else begin
            if (slv_req.ar_valid && !rd_ok) rd_stall_m++;
            if (slv_req.aw_valid && !wr_ok) wr_stall_m++;
        end
`endif
        @(posedge clk);
        if (rl_hs) void'(rd_q.pop_front());
        if (ar_hs) rd_q.push_back(int'(slv_req.ar.len));
        if (b_hs) void'(wr_q.pop_front());
        if (aw_hs) wr_q.push_back(int'(slv_req.aw.id));
        if (r_hs) rd_beat = rl_hs ? 0 : rd_beat + 1;
        ar_hs_last = ar_hs;
        aw_hs_last = aw_hs;
        #1;
        check("rd_inflight", rd_inflight, rd_q.size());
        check("wr_inflight", wr_inflight, wr_q.size());
        check("idle", idle, (rd_q.size() == 0) && (wr_q.size() == 0));
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        check("rd_stall", rd_stall, rd_stall_m);
        check("wr_stall", wr_stall, wr_stall_m);
`endif
        @(negedge clk);
    endtask

    function automatic bit r_last_now();
        if (rd_q.size() == 0) return 1'b0;
        return rd_beat == rd_q[0];
    endfunction

    task automatic drain();
        clr_in();
        slv_req.r_ready = 1'b1;
        slv_req.b_ready = 1'b1;
        for (int i = 0; i < 64 && (rd_q.size() != 0 || wr_q.size() != 0); i++) begin
            mst_resp.r_valid = (rd_q.size() != 0);
            mst_resp.r.last  = r_last_now();
            mst_resp.b_valid = (wr_q.size() != 0);
            step();
        end
        check("drain_idle", idle, 1'b1);
        clr_in();
    endtask

    task automatic rand_inputs();
        if (!slv_req.ar_valid || ar_hs_last) begin
            slv_req.ar_valid = ($urandom_range(0, 2) != 0);
            slv_req.ar.id    = 4'($urandom);
            slv_req.ar.addr  = $urandom;
            slv_req.ar.len   = 8'($urandom_range(0, 3));
        end
        if (!slv_req.aw_valid || aw_hs_last) begin
            slv_req.aw_valid = ($urandom_range(0, 2) != 0);
            slv_req.aw.id    = 4'($urandom);
            slv_req.aw.addr  = $urandom;
            slv_req.aw.len   = 8'($urandom_range(0, 3));
        end
        mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
        mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
        slv_req.w.data    = $urandom;
        slv_req.w.strb    = 4'($urandom);
        slv_req.w.last    = 1'($urandom);
        slv_req.w_valid   = 1'($urandom);
        mst_resp.w_ready  = 1'($urandom);
        mst_resp.r.id     = 4'($urandom);
        mst_resp.r.data   = $urandom;
        mst_resp.r.resp   = 2'($urandom);
        mst_resp.r.last   = r_last_now();
        mst_resp.r_valid  = (rd_q.size() != 0) && ($urandom_range(0, 2) == 0);
        slv_req.r_ready   = ($urandom_range(0, 3) != 0);
        mst_resp.b.id     = 4'($urandom);
        mst_resp.b.resp   = 2'($urandom);
        mst_resp.b_valid  = (wr_q.size() != 0) && ($urandom_range(0, 3) == 0);
        slv_req.b_ready   = ($urandom_range(0, 3) != 0);
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        stats_clr = ($urandom_range(0, 63) == 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clr_in();
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        rd_stall_m = 0;
        wr_stall_m = 0;
`endif
        @(negedge clk);
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        #1;
        check("reset_rd_cnt", rd_inflight, 0);
        check("reset_wr_cnt", wr_inflight, 0);
        check("reset_idle", idle, 1'b1);
        check("reset_no_stall", mst_req.ar_valid, 1'b1);
        clr_in();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill reads, third AR held until the cycle after an R-last.
        mst_resp.ar_ready = 1'b1;
        slv_req.ar_valid  = 1'b1;
        slv_req.ar        = '{id: 4'd1, addr: 32'h100, len: 8'd0};
        step();
        slv_req.ar.id = 4'd2;
        step();
        check("rd_fill_cnt", rd_inflight, 2);
        slv_req.ar.id = 4'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ar_held_valid", mst_req.ar_valid, 1'b0);
            check("ar_held_ready", slv_resp.ar_ready, 1'b0);
            step();
        end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        slv_req.r_ready  = 1'b1;
        #1;
        check("ar_no_bypass", mst_req.ar_valid, 1'b0);
        step();
        check("rd_after_rlast", rd_inflight, 1);
        mst_resp.r_valid = 1'b0;
        mst_resp.r.last  = 1'b0;
        #1;
        check("ar_release", mst_req.ar_valid, 1'b1);
        step();
        check("rd_refill", rd_inflight, 2);
        drain();

        // Four-beat read burst: count drops only on the last beat.
        slv_req.ar_valid  = 1'b1;
        slv_req.ar        = '{id: 4'd5, addr: 32'h200, len: 8'd3};
        mst_resp.ar_ready = 1'b1;
        step();
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        slv_req.r_ready  = 1'b1;
        for (int b = 0; b < 4; b++) begin
            mst_resp.r.data = $urandom;
            mst_resp.r.last = (b == 3);
            step();
            check("burst_cnt", rd_inflight, (b == 3) ? 0 : 1);
        end
        check("burst_idle", idle, 1'b1);
        clr_in();

        // Same-cycle AW and B at wr_cnt=1, then fill writes and release on B.
        slv_req.aw_valid  = 1'b1;
        slv_req.aw        = '{id: 4'd6, addr: 32'h300, len: 8'd3};
        mst_resp.aw_ready = 1'b1;
        step();
        slv_req.aw.id    = 4'd7;
        mst_resp.b_valid = 1'b1;
        slv_req.b_ready  = 1'b1;
        #1;
        check("aw_ready_same", slv_resp.aw_ready, 1'b1);
        step();
        check("wr_same_cycle", wr_inflight, 1);
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        step();
        check("wr_full_cnt", wr_inflight, 2);
        slv_req.aw.id    = 4'd8;
        mst_resp.w_ready = 1'b1;
        slv_req.w_valid  = 1'b1;
        for (int b = 0; b < 4; b++) begin
            slv_req.w.data = $urandom;
            slv_req.w.strb = 4'($urandom);
            slv_req.w.last = (b == 3);
            #1;
            check("aw_stall", mst_req.aw_valid, 1'b0);
            check("w_data", {mst_req.w.data, mst_req.w.strb}, {slv_req.w.data, slv_req.w.strb});
            step();
        end
        slv_req.w_valid  = 1'b0;
        mst_resp.b_valid = 1'b1;
        slv_req.b_ready  = 1'b1;
        #1;
        check("aw_stall_on_b", mst_req.aw_valid, 1'b0);
        step();
        mst_resp.b_valid = 1'b0;
        #1;
        check("aw_release", mst_req.aw_valid, 1'b1);
        step();
        check("wr_refill", wr_inflight, 2);
        drain();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            step();
        end
        drain();

        // Asynchronous reset with rd=2, wr=1.
        mst_resp.ar_ready = 1'b1;
        mst_resp.aw_ready = 1'b1;
        slv_req.ar_valid  = 1'b1;
        slv_req.aw_valid  = 1'b1;
        slv_req.ar        = '{id: 4'd9, addr: 32'h400, len: 8'd1};
        slv_req.aw        = '{id: 4'd9, addr: 32'h500, len: 8'd0};
        step();
        slv_req.aw_valid = 1'b0;
        step();
        check("pre_rst_rd", rd_inflight, 2);
        check("pre_rst_wr", wr_inflight, 1);
        clr_in();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd", rd_inflight, 0);
        check("async_rst_wr", wr_inflight, 0);
        check("async_rst_idle", idle, 1'b1);
        rd_q.delete();
        wr_q.delete();
        rd_beat = 0;
`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        rd_stall_m = 0;
        wr_stall_m = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

`ifdef AXI_INFLIGHT_LIMITER_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        mst_resp.ar_ready = 1'b1;
        slv_req.ar_valid  = 1'b1;
        slv_req.ar        = '{id: 4'd1, addr: 32'h600, len: 8'd0};
        step();
        step();
        for (int i = 0; i < 10; i++) step();
        check("rd_stall_10", rd_stall, 10);
        stats_clr = 1'b1;
        step();
        check("rd_stall_clr", rd_stall, 0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
